// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D main-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned ADDR_WIDTH_DEF     = 64;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } t_arb_state;

  // Requester identity; also used for the round-robin history
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } t_port;

  // The port that should win a tie given who was served last
  function automatic t_port other_port(input t_port p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave  : the arbiter's view.
// master : the requesters plus the memory, as seen from outside the arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  // requester side
  logic                  i_req_i;
  logic                  i_req_d;
  logic                  i_we_d;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic [ADDR_WIDTH-1:0] i_addr_d;
  logic [DATA_WIDTH-1:0] i_wdata_d;
  logic                  o_done_i;
  logic                  o_done_d;
  logic                  o_err_i;
  logic                  o_err_d;
  logic [DATA_WIDTH-1:0] o_rdata_i;
  logic [DATA_WIDTH-1:0] o_rdata_d;

  // memory side
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  o_mem_write_en;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic                  i_mem_access_ok;
  logic                  i_mem_read_ok;
  logic                  i_mem_write_ok;

  modport slave (
    input  i_req_i, i_req_d, i_we_d, i_addr_i, i_addr_d, i_wdata_d,
    input  i_mem_rdata, i_mem_access_ok, i_mem_read_ok, i_mem_write_ok,
    output o_done_i, o_done_d, o_err_i, o_err_d, o_rdata_i, o_rdata_d,
    output o_mem_addr, o_mem_wdata, o_mem_write_en
  );

  modport master (
    output i_req_i, i_req_d, i_we_d, i_addr_i, i_addr_d, i_wdata_d,
    output i_mem_rdata, i_mem_access_ok, i_mem_read_ok, i_mem_write_ok,
    input  o_done_i, o_done_d, o_err_i, o_err_d, o_rdata_i, o_rdata_d,
    input  o_mem_addr, o_mem_wdata, o_mem_write_en
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Watchdog for a single memory access: clearable up-counter with a
// terminal-count flag raised while the count equals TERMINAL.
module mem_arb_timer #(
  parameter int unsigned TERMINAL = 64
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int unsigned CW = $clog2(TERMINAL + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // clear has priority; otherwise count up when asked
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = (count_q == CW'(TERMINAL));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory between the
// instruction-fetch port (I, read-only) and the load/store port (D).
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// BUSY  | drive latched request to memory until it completes or times out
// RESP  | one-cycle done (and err on timeout) pulse to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic          i_clk,
  input logic          i_arst_n,
  mem_arbiter_if.slave bus
);

  t_arb_state            state_q,      state_d;
  t_port                 owner_q,      owner_d;
  t_port                 last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic                  we_q,         we_d;
  logic                  err_q,        err_d;
  logic [DATA_WIDTH-1:0] rdata_i_q,    rdata_i_d;
  logic [DATA_WIDTH-1:0] rdata_d_q,    rdata_d_d;

  t_port grant_port;
  logic  mem_ok;
  logic  timer_clr;
  logic  timer_inc;
  logic  timer_tc;

  mem_arb_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clr    (timer_clr),
    .i_inc    (timer_inc),
    .o_tc     (timer_tc)
  );

  // the memory finishes an access only when the matching direction is accepted
  assign mem_ok = bus.i_mem_access_ok &&
                  (we_q ? bus.i_mem_write_ok : bus.i_mem_read_ok);

  // next-state, arbitration, capture and watchdog control
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    err_d        = err_q;
    rdata_i_d    = rdata_i_q;
    rdata_d_d    = rdata_d_q;
    grant_port   = PORT_I;
    timer_clr    = 1'b1;
    timer_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_req_i && bus.i_req_d) begin
          grant_port = other_port(last_grant_q);
        end else if (bus.i_req_d) begin
          grant_port = PORT_D;
        end else begin
          grant_port = PORT_I;
        end

        if (bus.i_req_i || bus.i_req_d) begin
          owner_d = grant_port;
          err_d   = 1'b0;
          if (grant_port == PORT_D) begin
            addr_d  = bus.i_addr_d;
            wdata_d = bus.i_wdata_d;
            we_d    = bus.i_we_d;
          end else begin
            addr_d  = bus.i_addr_i;
            wdata_d = '0;
            we_d    = 1'b0;
          end
          // preload so the first BUSY cycle sees a count of 1
          timer_clr = 1'b0;
          timer_inc = 1'b1;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        timer_clr = 1'b0;
        if (mem_ok) begin
          // completion wins over a timeout landing in the same cycle
          if (!we_q) begin
            if (owner_q == PORT_I) begin
              rdata_i_d = bus.i_mem_rdata;
            end else begin
              rdata_d_d = bus.i_mem_rdata;
            end
          end
          err_d        = 1'b0;
          last_grant_d = owner_q;
          state_d      = RESP;
        end else if (timer_tc) begin
          // a timed-out owner still counts as served so the other port
          // is not starved behind a hung access
          err_d        = 1'b1;
          last_grant_d = owner_q;
          state_d      = RESP;
        end else begin
          timer_inc = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and latched-request registers
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      rdata_i_q    <= '0;
      rdata_d_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      err_q        <= err_d;
      rdata_i_q    <= rdata_i_d;
      rdata_d_q    <= rdata_d_d;
    end
  end

  // memory drive is gated to BUSY so IDLE/RESP present a quiet bus
  always_comb begin
    bus.o_mem_addr     = '0;
    bus.o_mem_wdata    = '0;
    bus.o_mem_write_en = 1'b0;
    if (state_q == BUSY) begin
      bus.o_mem_addr     = addr_q;
      bus.o_mem_wdata    = wdata_q;
      bus.o_mem_write_en = we_q && mem_ok;
    end
  end

  // requester responses
  always_comb begin
    bus.o_done_i  = (state_q == RESP) && (owner_q == PORT_I);
    bus.o_done_d  = (state_q == RESP) && (owner_q == PORT_D);
    bus.o_err_i   = bus.o_done_i && err_q;
    bus.o_err_d   = bus.o_done_d && err_q;
    bus.o_rdata_i = rdata_i_q;
    bus.o_rdata_d = rdata_d_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  logic clk;
  logic arst_n;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(64)) bus ();

  mem_arbiter #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (64),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: unwritten words read as A5000000 | word index
  logic [31:0] mem [256];
  logic        mem_vld [256];
  logic [7:0]  mem_idx;

  assign mem_idx         = bus.o_mem_addr[9:2];
  assign bus.i_mem_rdata = mem_vld[mem_idx] ? mem[mem_idx] : (32'hA500_0000 | {24'd0, mem_idx});

  always @(posedge clk) begin
    if (bus.o_mem_write_en) begin
      mem[mem_idx]     <= bus.o_mem_wdata;
      mem_vld[mem_idx] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          order_q[$];
  int          at_i, at_d;
  logic        err_i_seen, err_d_seen;
  int          wcnt;
  int          rem_i, rem_d;
  logic [63:0] addr_seen;

  // one negedge into the IDLE cycle so the next request is granted at once
  task automatic idle_gap();
    @(negedge clk);
  endtask

  // runs the requesters until all outstanding requests are done;
  // n counts negedges after the grant cycle, so n = k is BUSY cycle k
  task automatic run(input int max_cyc, input int period, input int ok_cycle);
    bit pend_i, pend_d, fin;
    pend_i = 0;
    pend_d = 0;
    fin    = 0;
    for (int n = 1; n <= max_cyc && !fin; n++) begin
      @(negedge clk);
      if (pend_i) begin bus.i_req_i = 1'b1; pend_i = 0; end
      if (pend_d) begin bus.i_req_d = 1'b1; pend_d = 0; end
      if (bus.o_done_i) begin
        order_q.push_back(0);
        at_i = n;
        err_i_seen = bus.o_err_i;
        bus.i_req_i = 1'b0;
        if (rem_i > 0) begin rem_i--; pend_i = 1; end
      end
      if (bus.o_done_d) begin
        order_q.push_back(1);
        at_d = n;
        err_d_seen = bus.o_err_d;
        bus.i_req_d = 1'b0;
        if (rem_d > 0) begin rem_d--; pend_d = 1; end
      end
      if (ok_cycle > 0)    bus.i_mem_access_ok = (n == ok_cycle);
      else if (period > 0) bus.i_mem_access_ok = ((n % period) == 0);
      else                 bus.i_mem_access_ok = 1'b0;
      #1;
      if (bus.o_mem_write_en) wcnt++;
      if (n == 2) addr_seen = bus.o_mem_addr;
      fin = !bus.i_req_i && !bus.i_req_d && !pend_i && !pend_d;
    end
    bus.i_mem_access_ok = 1'b0;
    check("run_bound", {63'd0, fin}, 64'd1);
  endtask

  task automatic req_i_rd(input logic [63:0] a);
    bus.i_addr_i = a;
    bus.i_req_i  = 1'b1;
  endtask

  task automatic req_d_acc(input logic we, input logic [63:0] a, input logic [31:0] wd);
    bus.i_we_d    = we;
    bus.i_addr_d  = a;
    bus.i_wdata_d = wd;
    bus.i_req_d   = 1'b1;
  endtask

  int w0;
  int dones;

  initial begin
    for (int k = 0; k < 256; k++) mem_vld[k] = 1'b0;
    arst_n              = 1'b0;
    bus.i_req_i         = 1'b0;
    bus.i_req_d         = 1'b0;
    bus.i_we_d          = 1'b0;
    bus.i_addr_i        = '0;
    bus.i_addr_d        = '0;
    bus.i_wdata_d       = '0;
    bus.i_mem_access_ok = 1'b0;
    bus.i_mem_read_ok   = 1'b1;
    bus.i_mem_write_ok  = 1'b1;
    wcnt = 0; rem_i = 0; rem_d = 0; at_i = 0; at_d = 0;
    err_i_seen = 1'b0; err_d_seen = 1'b0; addr_seen = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_done", {62'd0, bus.o_done_i, bus.o_done_d}, 64'd0);
    check("rst_err", {62'd0, bus.o_err_i, bus.o_err_d}, 64'd0);
    check("rst_rdata", {bus.o_rdata_i, bus.o_rdata_d}, 64'd0);
    check("rst_mem", bus.o_mem_addr | {32'd0, bus.o_mem_wdata} | {63'd0, bus.o_mem_write_en}, 64'd0);
    arst_n = 1'b1;

    // both requested from reset: I first, then D
    order_q.delete();
    idle_gap();
    req_i_rd(64'h104);
    req_d_acc(1'b0, 64'h200, 32'h0);
    run(100, 3, 0);
    check("tie_n", order_q.size(), 2);
    check("tie_first", order_q[0], 0);
    check("tie_second", order_q[1], 1);
    check("tie_at_i", at_i, 4);
    check("tie_at_d", at_d, 7);
    check("tie_rdata_i", bus.o_rdata_i, 64'hA500_0041);
    check("tie_rdata_d", bus.o_rdata_d, 64'hA500_0080);

    // both held: I,D,I,D,I,D
    order_q.delete();
    idle_gap();
    rem_i = 2; rem_d = 2;
    req_i_rd(64'h100);
    req_d_acc(1'b0, 64'h200, 32'h0);
    run(400, 3, 0);
    check("alt_n", order_q.size(), 6);
    for (int k = 0; k < order_q.size(); k++) check($sformatf("alt_%0d", k), order_q[k], k % 2);

    // I-only read, access_ok every 8th cycle
    order_q.delete();
    idle_gap();
    w0 = wcnt;
    req_i_rd(64'h100);
    run(100, 8, 0);
    check("ird_ndone", order_q.size(), 1);
    check("ird_at", at_i, 9);
    check("ird_rdata", bus.o_rdata_i, 64'hA500_0040);
    check("ird_nowrite", wcnt - w0, 0);
    check("ird_busy_addr", addr_seen, 64'h100);
    check("ird_resp_addr", bus.o_mem_addr, 64'h0);
    check("ird_err", {63'd0, err_i_seen}, 64'd0);

    // D write, then I reads it back
    idle_gap();
    w0 = wcnt;
    req_d_acc(1'b1, 64'h40, 32'hDEAD_BEEF);
    run(100, 4, 0);
    check("dwr_pulses", wcnt - w0, 1);
    check("dwr_at", at_d, 5);
    check("dwr_err", {63'd0, err_d_seen}, 64'd0);
    idle_gap();
    req_i_rd(64'h40);
    run(100, 2, 0);
    check("rdbk_at", at_i, 3);
    check("rdbk_rdata", bus.o_rdata_i, 64'hDEAD_BEEF);

    // access never completes: timeout 65 cycles after grant, no write
    idle_gap();
    w0 = wcnt;
    req_d_acc(1'b1, 64'h80, 32'h1111_1111);
    run(200, 0, 0);
    check("to_at", at_d, 65);
    check("to_err", {63'd0, err_d_seen}, 64'd1);
    check("to_nowrite", wcnt - w0, 0);
    check("to_rdata_d", bus.o_rdata_d, 64'hA500_0080);
    idle_gap();
    req_i_rd(64'h80);
    run(100, 2, 0);
    check("to_next_at", at_i, 3);
    check("to_next_rdata", bus.o_rdata_i, 64'hA500_0020);
    check("to_next_err", {63'd0, err_i_seen}, 64'd0);

    // completion on the timeout cycle is a success
    idle_gap();
    req_d_acc(1'b0, 64'h300, 32'h0);
    run(200, 0, 64);
    check("tc_at", at_d, 65);
    check("tc_err", {63'd0, err_d_seen}, 64'd0);
    check("tc_rdata", bus.o_rdata_d, 64'hA500_00C0);

    // reset during BUSY
    idle_gap();
    req_d_acc(1'b1, 64'h80, 32'h1234_5678);
    repeat (5) @(negedge clk);
    #2;
    bus.i_mem_access_ok = 1'b1;
    arst_n = 1'b0;
    #1;
    check("mrst_addr", bus.o_mem_addr, 64'h0);
    check("mrst_wdata", bus.o_mem_wdata, 64'h0);
    check("mrst_we", {63'd0, bus.o_mem_write_en}, 64'd0);
    check("mrst_done", {62'd0, bus.o_done_i, bus.o_done_d}, 64'd0);
    check("mrst_rdata", {bus.o_rdata_i, bus.o_rdata_d}, 64'd0);
    bus.i_req_d = 1'b0;
    bus.i_mem_access_ok = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_done_i || bus.o_done_d) dones++;
    end
    check("mrst_nodone", dones, 0);

    order_q.delete();
    idle_gap();
    req_i_rd(64'h100);
    req_d_acc(1'b0, 64'h200, 32'h0);
    run(100, 2, 0);
    check("mrst_tie_n", order_q.size(), 2);
    check("mrst_tie_first", order_q[0], 0);
    idle_gap();
    req_i_rd(64'h80);
    run(100, 2, 0);
    check("mrst_nowrite", bus.o_rdata_i, 64'hA500_0020);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
